// File: rtl/clock_pkg.sv
// clock_pkg: shared field limits and mode encodings for the hh:mm:ss timekeeper
package clock_pkg;
    localparam int FIELD_W  = 6;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    typedef enum logic [1:0] {
        MODE_RUN         = 2'd0,
        MODE_SET_HOURS   = 2'd1,
        MODE_SET_MINUTES = 2'd2
    } mode_t;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrapping 0..MAX counter with synchronous clear and a terminal-count carry
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0 (takes priority over inc)
//   inc      : advance by one, wrapping MAX -> 0
//   q        : current count
//   carry    : combinational, high when inc is high and q == MAX
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         carry
);
    logic at_max;

    assign at_max = q == W'(MAX);
    assign carry  = inc && at_max;

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc)
            q <= at_max ? '0 : q + W'(1);
    end
endmodule

// File: rtl/time_counter.sv
// time_counter: free-running hh:mm:ss timekeeper with prescaler and button-driven set modes
//   clk, rst  : clock, synchronous active-high reset
//   btn_mode  : one-cycle pulse, steps RUN -> SET_HOURS -> SET_MINUTES -> RUN
//   btn_inc   : one-cycle pulse, increments the field being set
//   seconds, minutes, hours : registered binary fields (0..59, 0..59, 0..23)
//   mode      : 0=RUN, 1=SET_HOURS, 2=SET_MINUTES
//   sec_tick  : one-cycle pulse the cycle after each prescaler wrap
//   blink     : blank phase for the field being set, 0 in RUN
module time_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [5:0] hours,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       blink
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    mode_t         st;
    logic [PW-1:0] presc;
    logic          wrap, run, leave_set, inc_ok;
    logic          s_carry, m_carry;

    assign wrap      = presc == LAST;
    assign run       = st == MODE_RUN;
    assign leave_set = btn_mode && st == MODE_SET_MINUTES;
    // a simultaneous mode press swallows the increment
    assign inc_ok    = btn_inc && !btn_mode;
    assign mode      = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= MODE_RUN;
            presc    <= '0;
            sec_tick <= 1'b0;
            blink    <= 1'b0;
        end else begin
            sec_tick <= wrap;
            // leaving set mode restarts the second so the first RUN tick is a full period away
            presc    <= (wrap || leave_set) ? '0 : presc + PW'(1);
            if (btn_mode) begin
                st    <= st == MODE_RUN ? MODE_SET_HOURS :
                         st == MODE_SET_HOURS ? MODE_SET_MINUTES : MODE_RUN;
                blink <= 1'b0;
            end else if (!run && wrap)
                blink <= ~blink;
        end
    end

    mod_counter #(.W(FIELD_W), .MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .clr   (leave_set),
        .inc   (run && wrap),
        .q     (seconds),
        .carry (s_carry)
    );

    mod_counter #(.W(FIELD_W), .MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   ((run && s_carry) || (st == MODE_SET_MINUTES && inc_ok)),
        .q     (minutes),
        .carry (m_carry)
    );

    mod_counter #(.W(FIELD_W), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   ((run && m_carry) || (st == MODE_SET_HOURS && inc_ok)),
        .q     (hours),
        .carry ()
    );
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed checks of time_counter plus a random range soak
module tb_time_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [5:0] seconds, minutes, hours;
    logic [1:0] mode;
    logic       sec_tick, blink;
    logic       rst2 = 1'b1, bm2 = 1'b0, bi2 = 1'b0;
    logic [5:0] s2, m2, h2;
    logic [1:0] mode2;
    logic       tick2, blink2;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    time_counter #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
        .mode     (mode),
        .sec_tick (sec_tick),
        .blink    (blink)
    );

    time_counter #(.TICK_DIV(2)) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .btn_mode (bm2),
        .btn_inc  (bi2),
        .seconds  (s2),
        .minutes  (m2),
        .hours    (h2),
        .mode     (mode2),
        .sec_tick (tick2),
        .blink    (blink2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        wait_n(1);
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            wait_n(1);
            btn_inc = 1'b0;
            wait_n(1);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_h"}, 32'(hours), 32'(h));
        chk({tag, "_m"}, 32'(minutes), 32'(m));
        chk({tag, "_s"}, 32'(seconds), 32'(s));
    endtask

    initial begin
        wait_n(2);
        rst = 1'b0;
        chk_time("reset", 0, 0, 0);
        chk("reset_mode", 32'(mode), 0);
        chk("reset_tick", 32'(sec_tick), 0);
        chk("reset_blink", 32'(blink), 0);
        wait_n(3);
        chk("tick_early", 32'(sec_tick), 0);
        wait_n(1);
        chk("tick_first", 32'(sec_tick), 1);
        chk("sec_first", 32'(seconds), 1);
        wait_n(1);
        chk("tick_one_cycle", 32'(sec_tick), 0);
        wait_n(3);
        chk("tick_period", 32'(sec_tick), 1);
        chk("sec_second", 32'(seconds), 2);

        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        chk("preload_mode", 32'(mode), 0);
        chk_time("preload", 23, 59, 0);
        wait_n(4 * 58);
        chk_time("t58", 23, 59, 58);
        wait_n(4);
        chk_time("t59", 23, 59, 59);
        wait_n(3);
        chk_time("t59_hold", 23, 59, 59);
        wait_n(1);
        chk_time("rollover", 0, 0, 0);
        chk("rollover_tick", 32'(sec_tick), 1);

        wait_n(12);
        chk("sec_three", 32'(seconds), 3);
        pulse_mode();
        chk("set_hours_mode", 32'(mode), 1);
        pulse_inc(25);
        chk_time("hours_wrap", 1, 0, 3);
        pulse_mode();
        chk("set_min_mode", 32'(mode), 2);
        pulse_inc(61);
        chk_time("min_wrap", 1, 1, 3);
        pulse_mode();
        chk("exit_mode", 32'(mode), 0);
        chk_time("exit_clear", 1, 1, 0);
        wait_n(3);
        chk("exit_tick_early", 32'(sec_tick), 0);
        wait_n(1);
        chk("exit_tick", 32'(sec_tick), 1);
        chk("exit_sec", 32'(seconds), 1);

        pulse_mode();
        pulse_mode();
        chk("both_pre_mode", 32'(mode), 2);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        wait_n(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        chk("both_mode", 32'(mode), 0);
        chk_time("both", 1, 1, 0);

        pulse_mode();
        chk("blink_entry", 32'(blink), 0);
        wait_n(2);
        chk("blink_pre", 32'(blink), 0);
        wait_n(1);
        chk("blink_1", 32'(blink), 1);
        wait_n(4);
        chk("blink_2", 32'(blink), 0);
        wait_n(4);
        chk("blink_3", 32'(blink), 1);
        chk_time("frozen", 1, 1, 0);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_blink", 32'(blink), 0);
        chk_time("rst", 0, 0, 0);

        rst2 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            bm2 = $urandom_range(0, 15) == 0;
            bi2 = $urandom_range(0, 3) == 0;
            wait_n(1);
            chk("soak_range", 32'(s2 < 60 && m2 < 60 && h2 < 24 && mode2 < 3 &&
                                  !(mode2 == 0 && blink2)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
